// File: rtl/sb_pkg.sv
// Shared widths and the per-entry payload type for the MEM-to-DM store buffer.
package sb_pkg;
   localparam int LANES      = 4;
   localparam int DATA_W     = 32;
   localparam int BE_W       = 4;
   localparam int PC_W       = 32;
   localparam int DEFAULT_AW = 30;

   // Word address is kept in its own array so the address width can be a top-level parameter
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [BE_W-1:0]   be;
      logic [PC_W-1:0]   pc;
   } sb_payload_t;
endpackage

// File: rtl/sb_fwd_lane.sv
// One byte lane of load forwarding: picks the youngest matching buffered byte, else DM read data.
module sb_fwd_lane #(
   parameter int DEPTH = 4
) (
   input  logic [DEPTH-1:0]      match,
   input  logic [DEPTH-1:0][7:0] lane_bytes,
   input  logic [7:0]            mem_byte,
   output logic [7:0]            byte_out,
   output logic                  hit
);

   // Inputs are ordered oldest (index 0) to youngest, so the last match seen wins
   always_comb begin
      byte_out = mem_byte;
      hit      = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (match[i]) begin
            byte_out = lane_bytes[i];
            hit      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/store_buffer.sv
// FIFO store buffer between MEM and data memory with per-byte load forwarding.
// Optional store coalescing into the youngest entry is enabled by STORE_BUFFER_COALESCE_EN.
module store_buffer
   import sb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = DEFAULT_AW
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     st_valid,
   input  logic [31:0]              st_addr,
   input  logic [31:0]              st_data,
   input  logic [3:0]               st_be,
   input  logic [31:0]              st_pc,
   output logic                     st_ready,
   input  logic [31:0]              ld_addr,
   input  logic [31:0]              ld_mem_rd,
   output logic [31:0]              ld_data,
   output logic                     ld_hit,
   output logic                     dm_we,
   output logic [31:0]              dm_addr,
   output logic [31:0]              dm_wd,
   output logic [3:0]               dm_be,
   output logic [31:0]              dm_pc,
   input  logic                     dm_ready,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0]       waddr_q [DEPTH];
   sb_payload_t         entry_q [DEPTH];
   logic [PW-1:0]       head_q, tail_q;
   logic [CW-1:0]       count_q;
   logic                retire, do_push;
   logic [LANES-1:0]    lane_hit;
   logic [DEPTH-1:0]    lane_match [LANES];
   logic [DEPTH-1:0][7:0] lane_bytes [LANES];
   logic                unused_bits;

   assign unused_bits = ^{ld_addr[1:0], st_addr[1:0]};

   // A reset cycle never presents a write, so DM cannot retire an entry that is being discarded
   assign dm_we   = !reset && (count_q != '0);
   assign retire  = dm_we && dm_ready;
   assign dm_addr = {waddr_q[head_q][AW-1:0], 2'b00};
   assign dm_wd   = entry_q[head_q].data;
   assign dm_be   = entry_q[head_q].be;
   assign dm_pc   = entry_q[head_q].pc;
   assign empty   = (count_q == '0);
   assign count   = count_q;

`ifdef STORE_BUFFER_COALESCE_EN
   logic [PW-1:0] ytail;
   logic          can_coalesce, do_coalesce;

   // The youngest entry may absorb a store unless it is the head leaving this cycle
   assign ytail        = tail_q - PW'(1);
   assign can_coalesce = (count_q != '0) && (waddr_q[ytail] == st_addr[31:2])
                         && !((count_q == CW'(1)) && retire);
   assign do_coalesce  = st_valid && (st_be != 4'b0000) && can_coalesce;
   assign st_ready     = (count_q < CW'(DEPTH)) || can_coalesce;
`else
   logic do_coalesce;
   assign do_coalesce = 1'b0;
   assign st_ready    = (count_q < CW'(DEPTH));
`endif

   assign do_push = st_valid && st_ready && (st_be != 4'b0000) && !do_coalesce;

   // Pointer, occupancy and entry update; no bypass in either the full or empty direction
   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) entry_q[i].be <= '0;
      end else begin
`ifdef STORE_BUFFER_COALESCE_EN
         if (do_coalesce) begin
            for (int l = 0; l < LANES; l++)
               if (st_be[l]) entry_q[ytail].data[8*l +: 8] <= st_data[8*l +: 8];
            entry_q[ytail].be <= entry_q[ytail].be | st_be;
            entry_q[ytail].pc <= st_pc;
         end
`endif
         if (do_push) begin
            waddr_q[tail_q]      <= st_addr[31:2];
            entry_q[tail_q].data <= st_data;
            entry_q[tail_q].be   <= st_be;
            entry_q[tail_q].pc   <= st_pc;
            tail_q               <= tail_q + PW'(1);
         end
         if (retire) head_q <= head_q + PW'(1);
         case ({do_push, retire})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Present live entries to the lane selectors in age order, oldest first
   always_comb begin
      logic [PW-1:0] slot;
      slot = '0;
      for (int l = 0; l < LANES; l++) begin
         lane_match[l] = '0;
         lane_bytes[l] = '0;
      end
      for (int k = 0; k < DEPTH; k++) begin
         slot = head_q + PW'(k);
         for (int l = 0; l < LANES; l++) begin
            lane_match[l][k] = (CW'(k) < count_q) && (waddr_q[slot] == ld_addr[31:2])
                               && entry_q[slot].be[l];
            lane_bytes[l][k] = entry_q[slot].data[8*l +: 8];
         end
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      sb_fwd_lane #(.DEPTH(DEPTH)) u_lane (
         .match      (lane_match[l]),
         .lane_bytes (lane_bytes[l]),
         .mem_byte   (ld_mem_rd[8*l +: 8]),
         .byte_out   (ld_data[8*l +: 8]),
         .hit        (lane_hit[l])
      );
   end

   assign ld_hit = |lane_hit;

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer; coalescing checks follow STORE_BUFFER_COALESCE_EN.
module tb_store_buffer;

   logic        clk;
   logic        reset;
   logic        st_valid;
   logic [31:0] st_addr, st_data, st_pc;
   logic [3:0]  st_be;
   logic        st_ready;
   logic [31:0] ld_addr, ld_mem_rd, ld_data;
   logic        ld_hit;
   logic        dm_we;
   logic [31:0] dm_addr, dm_wd, dm_pc;
   logic [3:0]  dm_be;
   logic        dm_ready;
   logic        empty;
   logic [2:0]  count;

   int checkCount = 0;
   int passCount  = 0;
   int wrN        = 0;
   int base;
   logic [31:0] wrAddr [64];
   logic [31:0] wrData [64];

   store_buffer #(.DEPTH(4), .AW(30)) dut (
      .clk(clk), .reset(reset),
      .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_be(st_be), .st_pc(st_pc),
      .st_ready(st_ready),
      .ld_addr(ld_addr), .ld_mem_rd(ld_mem_rd), .ld_data(ld_data), .ld_hit(ld_hit),
      .dm_we(dm_we), .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_be(dm_be), .dm_pc(dm_pc),
      .dm_ready(dm_ready), .empty(empty), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change at posedge+1, so the negedge view is exactly what DM sees at the next edge
   always @(negedge clk) begin
      if (dm_we && dm_ready) begin
         if (wrN < 64) begin
            wrAddr[wrN] = dm_addr;
            wrData[wrN] = dm_wd;
         end
         wrN = wrN + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic valid, input logic [31:0] addr, input logic [31:0] data,
                                input logic [3:0] be, input logic [31:0] pc);
      st_valid = valid;
      st_addr  = addr;
      st_data  = data;
      st_be    = be;
      st_pc    = pc;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected)
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
      else
         passCount++;
   endtask

   initial begin
      reset     = 1'b1;
      dm_ready  = 1'b0;
      ld_addr   = 32'h0;
      ld_mem_rd = 32'h0;
      applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      ld_mem_rd = 32'h12345678;
      #1;
      checkOutput("rst_count", {29'b0, count}, 32'd0);
      checkOutput("rst_st_ready", {31'b0, st_ready}, 32'd1);
      checkOutput("rst_dm_we", {31'b0, dm_we}, 32'd0);
      checkOutput("rst_empty", {31'b0, empty}, 32'd1);
      checkOutput("rst_ld_hit", {31'b0, ld_hit}, 32'd0);
      checkOutput("rst_ld_data", ld_data, 32'h12345678);

      // Basic drain
      base     = wrN;
      dm_ready = 1'b1;
      applyStimulus(1'b1, 32'h00000010, 32'hDEADBEEF, 4'hF, 32'h00001000);
      tick();
      applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
      checkOutput("drain_dm_we", {31'b0, dm_we}, 32'd1);
      checkOutput("drain_dm_addr", dm_addr, 32'h00000010);
      checkOutput("drain_dm_wd", dm_wd, 32'hDEADBEEF);
      checkOutput("drain_dm_be", {28'b0, dm_be}, 32'hF);
      checkOutput("drain_dm_pc", dm_pc, 32'h00001000);
      checkOutput("drain_empty_before", {31'b0, empty}, 32'd0);
      tick();
      checkOutput("drain_empty_after", {31'b0, empty}, 32'd1);
      checkOutput("drain_dm_we_after", {31'b0, dm_we}, 32'd0);
      checkOutput("drain_writes", wrN - base, 32'd1);
      checkOutput("drain_wr_addr", wrAddr[base], 32'h00000010);

      // Full and back-pressure
      dm_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 32'(i * 4), 32'hA0000000 + 32'(i), 4'hF, 32'h2000 + 32'(i));
         tick();
      end
      checkOutput("full_count", {29'b0, count}, 32'd4);
      checkOutput("full_st_ready", {31'b0, st_ready}, 32'd0);
      applyStimulus(1'b1, 32'h00000030, 32'h55555555, 4'hF, 32'h3000);
      tick();
      checkOutput("full_stall_count", {29'b0, count}, 32'd4);
      checkOutput("full_head_addr", dm_addr, 32'h00000000);
      applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
      base     = wrN;
      dm_ready = 1'b1;
      tick();
      checkOutput("bp_count_after1", {29'b0, count}, 32'd3);
      checkOutput("bp_head_after1", dm_addr, 32'h00000004);
      tick();
      tick();
      tick();
      checkOutput("bp_empty", {31'b0, empty}, 32'd1);
      checkOutput("bp_writes", wrN - base, 32'd4);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("bp_order%0d", i), wrAddr[base + i], 32'(i * 4));
         checkOutput($sformatf("bp_data%0d", i), wrData[base + i], 32'hA0000000 + 32'(i));
      end

      // Zero byte-enable store enqueues nothing
      dm_ready = 1'b0;
      applyStimulus(1'b1, 32'h00000070, 32'hFFFFFFFF, 4'h0, 32'h0);
      tick();
      checkOutput("be0_count", {29'b0, count}, 32'd0);

      // Forwarding merge
      applyStimulus(1'b1, 32'h00000020, 32'h00001122, 4'b0011, 32'h4000);
      tick();
      applyStimulus(1'b1, 32'h00000020, 32'h00334400, 4'b0110, 32'h4004);
      tick();
      applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
      ld_addr   = 32'h00000020;
      ld_mem_rd = 32'hAABBCCDD;
      #1;
      checkOutput("fwd_merge_data", ld_data, 32'hAA334422);
      checkOutput("fwd_merge_hit", {31'b0, ld_hit}, 32'd1);
      ld_addr = 32'h00000024;
      #1;
      checkOutput("fwd_miss_data", ld_data, 32'hAABBCCDD);
      checkOutput("fwd_miss_hit", {31'b0, ld_hit}, 32'd0);
      ld_addr  = 32'h00000020;
      dm_ready = 1'b1;
      #1;
      checkOutput("fwd_retiring_data", ld_data, 32'hAA334422);
      tick();
`ifdef STORE_BUFFER_COALESCE_EN
      checkOutput("fwd_after_retire", ld_data, 32'hAABBCCDD);
`else
      checkOutput("fwd_after_retire", ld_data, 32'hAA3344DD);
`endif
      tick();
      checkOutput("fwd_empty", {31'b0, empty}, 32'd1);

      // Simultaneous enqueue and retire
      dm_ready = 1'b0;
      applyStimulus(1'b1, 32'h00000050, 32'h00000001, 4'hF, 32'h5000);
      tick();
      applyStimulus(1'b1, 32'h00000054, 32'h00000002, 4'hF, 32'h5004);
      tick();
      checkOutput("sim_count_pre", {29'b0, count}, 32'd2);
      base     = wrN;
      dm_ready = 1'b1;
      applyStimulus(1'b1, 32'h00000058, 32'h00000003, 4'hF, 32'h5008);
      tick();
      applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
      checkOutput("sim_count", {29'b0, count}, 32'd2);
      checkOutput("sim_first_wr", wrAddr[base], 32'h00000050);
      tick();
      tick();
      checkOutput("sim_writes", wrN - base, 32'd3);
      checkOutput("sim_second_wr", wrAddr[base + 1], 32'h00000054);
      checkOutput("sim_third_wr", wrAddr[base + 2], 32'h00000058);
      checkOutput("sim_empty", {31'b0, empty}, 32'd1);

      // Reset mid-operation
      dm_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 32'h60 + 32'(i * 4), 32'hC0 + 32'(i), 4'hF, 32'h6000);
         tick();
      end
      applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
      checkOutput("rmid_count_pre", {29'b0, count}, 32'd3);
      base     = wrN;
      reset    = 1'b1;
      dm_ready = 1'b1;
      #1;
      checkOutput("rmid_dm_we_in_reset", {31'b0, dm_we}, 32'd0);
      tick();
      reset    = 1'b0;
      dm_ready = 1'b0;
      ld_addr  = 32'h00000060;
      #1;
      checkOutput("rmid_count", {29'b0, count}, 32'd0);
      checkOutput("rmid_dm_we", {31'b0, dm_we}, 32'd0);
      checkOutput("rmid_no_write", wrN - base, 32'd0);
      checkOutput("rmid_ld_hit", {31'b0, ld_hit}, 32'd0);
      checkOutput("rmid_ld_data", ld_data, 32'hAABBCCDD);

      // Coalescing of same-word stores (or two entries when disabled)
      applyStimulus(1'b1, 32'h00000040, 32'h00000011, 4'b0001, 32'h7000);
      tick();
      applyStimulus(1'b1, 32'h00000040, 32'h00002200, 4'b0010, 32'h7004);
      tick();
      applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
`ifdef STORE_BUFFER_COALESCE_EN
      checkOutput("coal_count", {29'b0, count}, 32'd1);
      checkOutput("coal_dm_be", {28'b0, dm_be}, 32'h3);
      checkOutput("coal_dm_wd_lo", {16'b0, dm_wd[15:0]}, 32'h00002211);
      checkOutput("coal_dm_pc", dm_pc, 32'h00007004);
`else
      checkOutput("nocoal_count", {29'b0, count}, 32'd2);
      checkOutput("nocoal_dm_be", {28'b0, dm_be}, 32'h1);
      checkOutput("nocoal_dm_wd_lo", {24'b0, dm_wd[7:0]}, 32'h00000011);
`endif

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- FIFO store buffer between the MEM stage and the data memory (DM).
- Accepts word/half/byte stores from the pipeline with byte enables and drains them to DM one per accepted cycle.
- Load-to-store forwarding merges pending bytes over DM read data, so loads never see stale memory.
- Decouples pipeline stores from a DM port that may back-pressure via dm_ready.

Parameters:
DEPTH, 4, number of entries; power of two, >= 2
AW, 30, stored word-address width (address bits [31:2])

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
st_valid  in  1  MEM stage presents a store
st_addr  in  32  byte address; bits [1:0] ignored
st_data  in  32  store data, already lane-aligned
st_be  in  4  byte enables; 4'b0000 is legal and enqueues nothing
st_pc  in  32  PC of the store, carried for DM trace
st_ready  out  1  buffer can accept this cycle
ld_addr  in  32  load address from MEM stage
ld_mem_rd  in  32  DM combinational read data for ld_addr
ld_data  out  32  merged load data
ld_hit  out  1  at least one byte of ld_data came from the buffer
dm_we  out  1  head entry valid, write request to DM
dm_addr  out  32  {head word address, 2'b00}
dm_wd  out  32  head data
dm_be  out  4  head byte enables
dm_pc  out  32  head PC
dm_ready  in  1  DM accepts the write at this posedge
empty  out  1  no pending entries
count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Storage: circular array of DEPTH entries {waddr[AW-1:0], data, be, pc}; head/tail pointers wrap modulo DEPTH; count register.
- Reset: entries' be cleared, head=tail=0, count=0. Outputs: st_ready=1, dm_we=0, empty=1, ld_hit=0, ld_data=ld_mem_rd. Reset mid-operation discards all pending stores, and nothing drains in that cycle.
- st_ready = (count < DEPTH). No full-bypass: when full, stores stall even if the head drains in the same cycle.
- Enqueue: st_valid && st_ready && st_be!=0 writes the entry at tail; tail++, count++.
- Drain: dm_we = !empty. Head retires when dm_we && dm_ready; head++, count--.
- Simultaneous enqueue and retire: count unchanged; both pointers advance.
- Latency: a store enqueued at edge N is presented on dm_* after edge N, and reaches DM at the first edge with dm_ready=1. There is no empty-bypass.
- Ordering: strict FIFO. DM write order equals program order.
- Forwarding: combinational, per byte lane i.
  - Among valid entries with waddr == ld_addr[31:2] and be[i]=1, take the youngest (closest to tail).
  - Otherwise take ld_mem_rd byte i.
  - The head entry retiring this cycle still forwards, because DM is not updated until the edge.
  - ld_hit = OR over lanes of "sourced from buffer".
- Same address, different lanes in different entries: lanes merge independently.

Optional Feature:
- Macro: STORE_BUFFER_COALESCE_EN.
- Defined:
  - An incoming store coalesces into the youngest entry (tail-1) when all of the following hold: count >= 1; that entry's waddr equals st_addr[31:2]; and that entry is not retiring this cycle (count==1 && dm_we && dm_ready blocks coalescing).
  - Coalesce: data lanes with st_be set are overwritten, be |= st_be, pc updated to st_pc. Tail and count are unchanged.
  - st_ready is 1 whenever coalescing is possible, even when full.
- Undefined: every store takes a new entry, as described in Behaviour.

Decomposition:
- Package sb_pkg: entry struct/field widths (AW, data 32, be 4, pc 32) and the lane count constant 4.
- One natural sub-module, sb_fwd_lane: per-byte youngest-match priority select. Instantiate it 4 times.

Test Plan:
- Basic drain: dm_ready=1; store 0x00000010/0xDEADBEEF/be=F -> next cycle dm_we=1, dm_addr=0x10, dm_wd=0xDEADBEEF; empty=1 one cycle later.
- Full/back-pressure: dm_ready=0; 4 stores to 0x0,0x4,0x8,0xC -> count=4, st_ready=0. Raise dm_ready -> writes appear in order 0x0,0x4,0x8,0xC, one per cycle.
- Forwarding merge: pending 0x20 be=0011 data=0x0000_1122, then 0x20 be=0110 data=0x0033_4400. Load 0x20 with ld_mem_rd=0xAABBCCDD -> ld_data=0xAA334422, ld_hit=1. Load 0x24 -> ld_data=ld_mem_rd, ld_hit=0.
- Simultaneous enqueue and retire at count=2 -> count stays 2; DM sees the oldest entry first.
- Reset mid-operation: 3 pending, reset=1 for one cycle -> count=0, dm_we=0, and no DM write in the reset cycle.
- With STORE_BUFFER_COALESCE_EN, dm_ready=0: stores 0x40 be=0001 0x11, then be=0010 0x2200 -> count=1, dm_be=0011, dm_wd[15:0]=0x2211.
